// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and state enum for the exe_muldiv unit.
// MULDIV_MADD_EN turns on the MADD/MADDU op codes.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int ITERS = WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MADD  = 3'b100;
  localparam logic [2:0] OP_MADDU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic op_valid(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
    return op <= OP_MADDU;
`else
    return op <= OP_DIVU;
`endif
  endfunction

  // Even codes (MULT, DIV, MADD) are the signed variants.
  function automatic logic op_signed(input logic [2:0] op);
    return !op[0];
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/exe_muldiv_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
// The execute stage drives through master; the unit connects as slave.
interface exe_muldiv_if #(
  parameter int WIDTH = muldiv_pkg::WIDTH
);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mem_ready;
  logic             imem_ready;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b, mem_ready, imem_ready, cancel, hi_we, lo_we, wdata,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b, mem_ready, imem_ready, cancel, hi_we, lo_we, wdata,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shift in the next dividend bit and subtract the
// divisor if it fits. The incoming remainder is always below the divisor.
module muldiv_divstep #(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted  = {rem, dbit};
    diff     = {1'b0, shifted} - {2'b00, divisor};
    q_bit    = !diff[WIDTH+1];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning architectural HI/LO; 34-cycle latency.
// Define MULDIV_MADD_EN to add MADD/MADDU (accumulate product into {HI,LO}).
//
// state | meaning
// IDLE  | waiting for issue; MTHI/MTLO writes applied here
// CALC  | one radix-2 step per cycle (shift-add or restoring subtract)
// FIX   | sign correction and HI/LO write-back, done pulse follows
module exe_muldiv #(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input logic         clock,
  input logic         resetn,
  exe_muldiv_if.slave bus
);
  import muldiv_pkg::*;

  localparam int ITERS = WIDTH;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               bz_q, bz_d;
  logic [WIDTH-1:0]   orig_a_q, orig_a_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               accept;
  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   rem_next;
  logic               q_bit;

  // Divide: acc holds {partial remainder, dividend/quotient}.
  muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem      (acc_q[2*WIDTH-1:WIDTH]),
    .dbit     (acc_q[WIDTH-1]),
    .divisor  (opnd_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bz_d      = bz_q;
    orig_a_d  = orig_a_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = dz_q;

    sa     = op_signed(bus.op) && bus.a[WIDTH-1];
    sb     = op_signed(bus.op) && bus.b[WIDTH-1];
    mag_a  = sa ? -bus.a : bus.a;
    mag_b  = sb ? -bus.b : bus.b;
    accept = (state_q == IDLE) && bus.start && bus.mem_ready && bus.imem_ready
             && op_valid(bus.op) && !bus.cancel;

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    prod    = neg_res_q ? -acc_q : acc_q;
    quo     = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem     = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = CALC;
          cnt_d     = '0;
          op_d      = bus.op;
          neg_res_d = sa ^ sb;
          neg_rem_d = sa;
          bz_d      = op_is_div(bus.op) && (bus.b == '0);
          orig_a_d  = bus.a;
          dz_d      = 1'b0;
          if (op_is_div(bus.op)) begin
            opnd_d = mag_b;
            acc_d  = {{WIDTH{1'b0}}, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {{WIDTH{1'b0}}, mag_b};
          end
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          if (op_is_div(op_q)) acc_d = {rem_next, acc_q[WIDTH-2:0], q_bit};
          else                 acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.cancel) begin
          done_d = 1'b1;
          if (op_is_div(op_q)) begin
            dz_d = bz_q;
            if (bz_q) begin
              lo_d = '1;
              hi_d = orig_a_q;
            end else begin
              lo_d = quo;
              hi_d = rem;
            end
          end else begin
`ifdef MULDIV_MADD_EN
            {hi_d, lo_d} = op_q[2] ? ({hi_q, lo_q} + prod) : prod;
`else
            {hi_d, lo_d} = prod;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bz_q      <= 1'b0;
      orig_a_q  <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bz_q      <= bz_d;
      orig_a_q  <= orig_a_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: arithmetic vectors, issue control, MT writes.
// Build with MULDIV_MADD_EN to exercise the accumulate ops instead of their rejection.
module tb_exe_muldiv;
  import muldiv_pkg::*;

  logic clock;
  logic resetn;
  int   n_cmp;
  int   n_err;
  int   cyc;

  exe_muldiv_if #(.WIDTH(32)) bus ();

  exe_muldiv #(.WIDTH(32)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    cyc       = 0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc, output int nbusy);
    done_cyc = 0;
    nbusy    = 0;
    while (cyc <= 40 && done_cyc == 0) begin
      if (bus.done) done_cyc = cyc;
      else begin
        if (bus.busy) nbusy++;
        tick();
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int dc, nb;
    issue(op, a, b);
    wait_done(dc, nb);
    chk_eq({tag, ".done_cyc"}, 32'(dc), 32'd34);
    chk_eq({tag, ".busy_cycles"}, 32'(nb), 32'd33);
    chk_eq({tag, ".hi"}, bus.hi, exp_hi);
    chk_eq({tag, ".lo"}, bus.lo, exp_lo);
  endtask

  task automatic mt_write(input logic hwe, input logic lwe, input logic [31:0] d);
    bus.hi_we = hwe;
    bus.lo_we = lwe;
    bus.wdata = d;
    tick();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  initial begin
    int  dc, nb;
    logic saw_done;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    resetn         = 1'b0;
    bus.start      = 1'b0;
    bus.op         = OP_MULT;
    bus.a          = '0;
    bus.b          = '0;
    bus.mem_ready  = 1'b1;
    bus.imem_ready = 1'b1;
    bus.cancel     = 1'b0;
    bus.hi_we      = 1'b0;
    bus.lo_we      = 1'b0;
    bus.wdata      = '0;
    repeat (2) tick();
    resetn = 1'b1;
    tick();

    chk_eq("rst.hi", bus.hi, 32'h0);
    chk_eq("rst.lo", bus.lo, 32'h0);
    chk_eq("rst.busy", 32'(bus.busy), 32'd0);
    chk_eq("rst.done", 32'(bus.done), 32'd0);
    chk_eq("rst.dz", 32'(bus.div_by_zero), 32'd0);

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    chk_eq("multu_max.busy_at_done", 32'(bus.busy), 32'd0);
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("div_neg_a", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_neg_b", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    chk_eq("divu_zero.dz", 32'(bus.div_by_zero), 32'd1);
    run_op("multu_after_dz", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
    chk_eq("multu_after_dz.dz", 32'(bus.div_by_zero), 32'd0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    chk_eq("div_ovf.dz", 32'(bus.div_by_zero), 32'd0);

    // Issue gating: stalled caches, invalid op, cancel in IDLE
    bus.mem_ready = 1'b0;
    issue(OP_MULTU, 32'd9, 32'd9);
    chk_eq("stall_mem.busy", 32'(bus.busy), 32'd0);
    bus.mem_ready  = 1'b1;
    bus.imem_ready = 1'b0;
    issue(OP_MULTU, 32'd9, 32'd9);
    chk_eq("stall_imem.busy", 32'(bus.busy), 32'd0);
    bus.imem_ready = 1'b1;
    issue(3'b110, 32'd9, 32'd9);
    chk_eq("bad_op.busy", 32'(bus.busy), 32'd0);
    bus.cancel = 1'b1;
    issue(OP_MULTU, 32'd9, 32'd9);
    bus.cancel = 1'b0;
    chk_eq("idle_cancel.busy", 32'(bus.busy), 32'd0);
    tick();
    chk_eq("gating.lo_kept", bus.lo, 32'h8000_0000);

    // Second start while busy is ignored
    issue(OP_MULTU, 32'd2, 32'd3);
    while (cyc < 5) tick();
    bus.start = 1'b1;
    bus.a     = 32'd10;
    bus.b     = 32'd10;
    tick();
    bus.start = 1'b0;
    wait_done(dc, nb);
    chk_eq("double_issue.done_cyc", 32'(dc), 32'd34);
    chk_eq("double_issue.lo", bus.lo, 32'd6);
    tick();
    chk_eq("double_issue.no_second", 32'(bus.busy), 32'd0);

    // Cancel at cycle 10
    issue(OP_MULTU, 32'd3, 32'd5);
    while (cyc < 10) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk_eq("cancel.busy_c11", 32'(bus.busy), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) saw_done = 1'b1;
      tick();
    end
    chk_eq("cancel.no_done", 32'(saw_done), 32'd0);
    chk_eq("cancel.hi", bus.hi, 32'd0);
    chk_eq("cancel.lo", bus.lo, 32'd6);

    // Reset at cycle 20
    run_op("pre_reset", OP_MULTU, 32'h0001_0001, 32'h0003_0000, 32'd3, 32'h0003_0000);
    issue(OP_MULTU, 32'd1, 32'd1);
    while (cyc < 20) tick();
    resetn = 1'b0;
    tick();
    chk_eq("midrst.hi", bus.hi, 32'h0);
    chk_eq("midrst.lo", bus.lo, 32'h0);
    chk_eq("midrst.busy", 32'(bus.busy), 32'd0);
    resetn = 1'b1;
    tick();

    // MTHI/MTLO
    mt_write(1'b1, 1'b1, 32'h0000_ABCD);
    chk_eq("mt_both.hi", bus.hi, 32'h0000_ABCD);
    chk_eq("mt_both.lo", bus.lo, 32'h0000_ABCD);
    mt_write(1'b0, 1'b1, 32'h0000_1234);
    chk_eq("mtlo.lo", bus.lo, 32'h0000_1234);
    chk_eq("mtlo.hi", bus.hi, 32'h0000_ABCD);
    mt_write(1'b1, 1'b0, 32'h0);
    chk_eq("mthi.hi", bus.hi, 32'h0);

    issue(OP_MULTU, 32'd1, 32'd1);
    while (cyc < 5) tick();
    mt_write(1'b1, 1'b0, 32'h0000_DEAD);
    chk_eq("mthi_busy.hi", bus.hi, 32'h0);
    wait_done(dc, nb);
    chk_eq("mthi_busy.done_cyc", 32'(dc), 32'd34);
    chk_eq("mthi_busy.lo", bus.lo, 32'd1);

    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_5555;
    issue(OP_MULTU, 32'd2, 32'd2);
    bus.lo_we = 1'b0;
    chk_eq("mt_drop.lo_c1", bus.lo, 32'd1);
    wait_done(dc, nb);
    chk_eq("mt_drop.lo", bus.lo, 32'd4);

    mt_write(1'b1, 1'b1, 32'h0);
    mt_write(1'b0, 1'b1, 32'h0000_1234);
`ifdef MULDIV_MADD_EN
    run_op("maddu", OP_MADDU, 32'd2, 32'd3, 32'h0, 32'h0000_123A);
    run_op("madd_neg", OP_MADD, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0000_1239);
`else
    issue(OP_MADDU, 32'd2, 32'd3);
    chk_eq("maddu_off.busy", 32'(bus.busy), 32'd0);
    issue(OP_MADD, 32'd2, 32'd3);
    chk_eq("madd_off.busy", 32'(bus.busy), 32'd0);
    tick();
    chk_eq("madd_off.lo", bus.lo, 32'h0000_1234);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
